// File: rtl/riscv_ascon_state_writeback.sv
// riscv_ascon_state_writeback
// Buffers one 320-bit Ascon state {x0..x4} and writes it to the GPR file as
// ten 32-bit words: a2-a7 (x12-x17), then t3-t6 (x28-x31).
// Each word is arbitrated against core writeback through the rf_gnt_* inputs.
// Optional macro ASCON_WB_DUAL_PORT_EN: writes two words per cycle on ports
// A and B. A pair advances only when both ports are granted in the same cycle.
// Without the macro, port B is tied off and only port A is used.
module riscv_ascon_state_writeback #(
  parameter int SWAP_ENDIAN = 1,
  parameter int NUM_WORDS   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         state_valid_i,
  output logic         state_ready_o,
  input  logic [319:0] state_i,
  output logic         rf_we_a_o,
  output logic [4:0]   rf_waddr_a_o,
  output logic [31:0]  rf_wdata_a_o,
  input  logic         rf_gnt_a_i,
  output logic         rf_we_b_o,
  output logic [4:0]   rf_waddr_b_o,
  output logic [31:0]  rf_wdata_b_o,
  input  logic         rf_gnt_b_i,
  output logic         busy_o,
  output logic         done_o
);

  // The GPR map is hard-wired for exactly ten words.
  if (NUM_WORDS != 10) begin : g_bad_num_words
    $error("riscv_ascon_state_writeback: NUM_WORDS must be 10");
  end

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_e;

`ifdef ASCON_WB_DUAL_PORT_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
  localparam logic [3:0] IDX_STEP = 4'd2;
`else
  localparam logic [3:0] LAST_IDX = 4'd9;
  localparam logic [3:0] IDX_STEP = 4'd1;
`endif

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [319:0]   buf_q, buf_d;
  logic           adv;
  logic           we_a, we_b;
  logic [3:0]     idx_b;

  // Word i is the i-th 32-bit slice counted from the MSB: x0.hi, x0.lo, x1.hi, ...
  function automatic logic [31:0] word_at(input logic [319:0] b, input logic [3:0] i);
    logic [319:0] sh;
    sh = b << {i, 5'b0};
    return sh[319:288];
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return (SWAP_ENDIAN != 0) ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  // idx 0..5 -> x12..x17, idx 6..9 -> x28..x31
  function automatic logic [4:0] gpr_of(input logic [3:0] i);
    return (i < 4'd6) ? 5'd12 + {1'b0, i} : 5'd22 + {1'b0, i};
  endfunction

`ifdef ASCON_WB_DUAL_PORT_EN
  assign adv = rf_gnt_a_i && rf_gnt_b_i;
`else
  assign adv = rf_gnt_a_i;
  // Port B is not used in the single-port build.
  logic unused_gnt_b;
  assign unused_gnt_b = rf_gnt_b_i;
`endif

  // FSM state, word index and state buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic and handshake/control outputs.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    state_ready_o = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    we_a          = 1'b0;
    we_b          = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_ready_o = 1'b1;
        if (state_valid_i) begin
          buf_d   = state_i;
          idx_d   = 4'd0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        busy_o = 1'b1;
        we_a   = 1'b1;
`ifdef ASCON_WB_DUAL_PORT_EN
        we_b   = 1'b1;
`endif
        if (adv) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + IDX_STEP;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign idx_b = idx_q + 4'd1;

  // Address/data come only from registered state; zero when not requesting.
  assign rf_we_a_o    = we_a;
  assign rf_waddr_a_o = we_a ? gpr_of(idx_q) : 5'd0;
  assign rf_wdata_a_o = we_a ? swap32(word_at(buf_q, idx_q)) : 32'd0;
  assign rf_we_b_o    = we_b;
  assign rf_waddr_b_o = we_b ? gpr_of(idx_b) : 5'd0;
  assign rf_wdata_b_o = we_b ? swap32(word_at(buf_q, idx_b)) : 32'd0;

endmodule

// File: tb/tb_riscv_ascon_state_writeback.sv
// Directed bench for riscv_ascon_state_writeback. Two instances share all
// inputs: dut (SWAP_ENDIAN=1) and dut0 (SWAP_ENDIAN=0). Inputs are driven and
// outputs are sampled on the falling clock edge.
module tb_riscv_ascon_state_writeback;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic [319:0] st = '0;
  logic         gnt_a = 1'b0;
  logic         gnt_b = 1'b0;

  logic         rdy, we_a, we_b, busy, done;
  logic [4:0]   waddr_a, waddr_b;
  logic [31:0]  wdata_a, wdata_b;
  logic         rdy0, we_a0, we_b0, busy0, done0;
  logic [4:0]   waddr_a0, waddr_b0;
  logic [31:0]  wdata_a0, wdata_b0;

  int errors = 0;
  int checks = 0;

  int gpr_tab [10] = '{12, 13, 14, 15, 16, 17, 28, 29, 30, 31};

  always #5 clk = ~clk;

  riscv_ascon_state_writeback #(.SWAP_ENDIAN(1), .NUM_WORDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .state_valid_i(valid), .state_ready_o(rdy), .state_i(st),
    .rf_we_a_o(we_a), .rf_waddr_a_o(waddr_a), .rf_wdata_a_o(wdata_a), .rf_gnt_a_i(gnt_a),
    .rf_we_b_o(we_b), .rf_waddr_b_o(waddr_b), .rf_wdata_b_o(wdata_b), .rf_gnt_b_i(gnt_b),
    .busy_o(busy), .done_o(done)
  );

  riscv_ascon_state_writeback #(.SWAP_ENDIAN(0), .NUM_WORDS(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .state_valid_i(valid), .state_ready_o(rdy0), .state_i(st),
    .rf_we_a_o(we_a0), .rf_waddr_a_o(waddr_a0), .rf_wdata_a_o(wdata_a0), .rf_gnt_a_i(gnt_a),
    .rf_we_b_o(we_b0), .rf_waddr_b_o(waddr_b0), .rf_wdata_b_o(wdata_b0), .rf_gnt_b_i(gnt_b),
    .busy_o(busy0), .done_o(done0)
  );

  function automatic logic [31:0] raw_word(input logic [319:0] s, input int k);
    return s[319-32*k -: 32];
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [319:0] make_ramp();
    logic [319:0] s;
    for (int i = 0; i < 5; i++) s[319-64*i -: 64] = 64'h0001020304050607 + 64'(i);
    return s;
  endfunction

  // One full state: accept, ten (or five paired) writes with an optional
  // grant stall at write step stall_k, then the done pulse. hold keeps valid
  // high afterwards so the next call exercises a back-to-back accept.
  task automatic run_state(input logic [319:0] s, input int stall_k, input int stall_n,
                           input bit hold, input string tag);
    int n;
    logic [4:0]  ea, eb;
    logic [31:0] ed, ed0, edb;
    checks++;
    if ({rdy, done, we_a, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_idle {rdy,done,we,busy} got=%b exp=1000", tag, {rdy, done, we_a, busy});
    end
    valid = 1'b1; st = s; gnt_a = 1'b1; gnt_b = 1'b1;
    @(negedge clk);
    if (!hold) valid = 1'b0;
`ifdef ASCON_WB_DUAL_PORT_EN
    for (int p = 0; p < 5; p++) begin
      n = (p == stall_k) ? stall_n : 0;
      for (int c = 0; c <= n; c++) begin
        ea  = 5'(gpr_tab[2*p]);
        eb  = 5'(gpr_tab[2*p+1]);
        ed  = bswap(raw_word(s, 2*p));
        edb = bswap(raw_word(s, 2*p+1));
        checks++;
        if ({we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, rdy, busy, done} !==
            {1'b1, ea, ed, 1'b1, eb, edb, 1'b0, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL %s_pair%0d a=%0d/%h b=%0d/%h rdy=%b busy=%b done=%b exp a=%0d/%h b=%0d/%h",
                   tag, p, waddr_a, wdata_a, waddr_b, wdata_b, rdy, busy, done, ea, ed, eb, edb);
        end
        ed0 = raw_word(s, 2*p);
        checks++;
        if ({waddr_a0, wdata_a0} !== {ea, ed0}) begin
          errors++;
          $display("FAIL %s_noswap_pair%0d got=%0d/%h exp=%0d/%h", tag, p, waddr_a0, wdata_a0, ea, ed0);
        end
        gnt_a = 1'b1;
        gnt_b = (c == n);
        @(negedge clk);
      end
    end
`else
    for (int k = 0; k < 10; k++) begin
      n = (k == stall_k) ? stall_n : 0;
      for (int c = 0; c <= n; c++) begin
        ea = 5'(gpr_tab[k]);
        ed = bswap(raw_word(s, k));
        checks++;
        if ({we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, rdy, busy, done} !==
            {1'b1, ea, ed, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL %s_word%0d a=%b/%0d/%h b=%b/%0d/%h rdy=%b busy=%b done=%b exp a=%0d/%h",
                   tag, k, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, rdy, busy, done, ea, ed);
        end
        ed0 = raw_word(s, k);
        checks++;
        if ({we_a0, waddr_a0, wdata_a0} !== {1'b1, ea, ed0}) begin
          errors++;
          $display("FAIL %s_noswap_word%0d got=%0d/%h exp=%0d/%h", tag, k, waddr_a0, wdata_a0, ea, ed0);
        end
        gnt_a = (c == n);
        // Port B grant toggles freely; it must have no effect in this build.
        gnt_b = ~gnt_b;
        @(negedge clk);
      end
    end
`endif
    gnt_a = 1'b0; gnt_b = 1'b0;
    checks++;
    if ({done, done0, we_a, busy, rdy} !== 5'b11000) begin
      errors++;
      $display("FAIL %s_done {done,done0,we,busy,rdy} got=%b exp=11000", tag, {done, done0, we_a, busy, rdy});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse got=%b exp=0", tag, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rdy, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, busy, done} !==
        {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b we=%b/%b addr=%0d/%0d busy=%b done=%b exp rdy=1 rest 0",
               rdy, we_a, we_b, waddr_a, waddr_b, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_state(make_ramp(), -1, 0, 1'b0, "basic");
  endtask

  task automatic test_stall();
`ifdef ASCON_WB_DUAL_PORT_EN
    run_state(make_ramp(), 1, 1, 1'b0, "stall");
`else
    run_state(make_ramp(), 4, 3, 1'b0, "stall");
`endif
  endtask

  task automatic test_back_to_back();
    logic [319:0] s2;
    s2 = ~make_ramp();
    run_state(s2, -1, 0, 1'b1, "b2b_first");
    run_state(make_ramp(), -1, 0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int grants;
`ifdef ASCON_WB_DUAL_PORT_EN
    grants = 3;
`else
    grants = 6;
`endif
    valid = 1'b1; st = make_ramp(); gnt_a = 1'b1; gnt_b = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int g = 0; g < grants; g++) @(negedge clk);
    checks++;
    if ({we_a, waddr_a} !== {1'b1, 5'd28}) begin
      errors++;
      $display("FAIL rstmid_pre we/addr got=%b/%0d exp=1/28", we_a, waddr_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, busy, done} !==
        {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_async rdy=%b we=%b addr=%0d data=%h busy=%b done=%b exp rdy=1 rest 0",
               rdy, we_a, waddr_a, wdata_a, busy, done);
    end
    gnt_a = 1'b0; gnt_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({done, we_a, rdy} !== 3'b001) begin
        errors++;
        $display("FAIL rstmid_idle%0d {done,we,rdy} got=%b exp=001", c, {done, we_a, rdy});
      end
    end
    run_state(make_ramp(), -1, 0, 1'b0, "rstmid_restart");
  endtask

  task automatic test_swap();
    logic [319:0] s;
    s = {10{32'hDEADBEEF}};
    run_state(s, -1, 0, 1'b0, "deadbeef");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_swap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
